// File: rtl/host_bus_iface_if.sv
// Bundles the asynchronous host bus and the synchronous VRAM host port
// seen by host_bus_iface.
interface host_bus_iface_if #(
    parameter int ADDR_W = 13
);
    logic              busCs_n;
    logic              busRd_n;
    logic              busWr_n;
    logic [1:0]        busReg;
    logic [7:0]        busDataIn;
    logic [7:0]        busDataOut;
    logic              busDataOe;
    logic [ADDR_W-1:0] hostAddr;
    logic [7:0]        hostWrData;
    logic              hostSelect;
    logic              hostRd;
    logic [7:0]        hostRdData;

    modport slave (
        input  busCs_n, busRd_n, busWr_n, busReg, busDataIn, hostRdData,
        output busDataOut, busDataOe, hostAddr, hostWrData, hostSelect, hostRd
    );

    modport master (
        output busCs_n, busRd_n, busWr_n, busReg, busDataIn, hostRdData,
        input  busDataOut, busDataOe, hostAddr, hostWrData, hostSelect, hostRd
    );
endinterface

// File: rtl/host_bus_iface.sv
// Host-side port of the text-mode VGA core: turns an asynchronous 8-bit MCU
// bus into single-cycle VRAM accesses behind an auto-incrementing pointer.
module host_bus_iface #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 13   // must be 9..16 so ADDR_HI holds the top bits
) (
    input  logic             clk,
    input  logic             rst,
    host_bus_iface_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, FETCH, CAPTURE} state_t;

    localparam int SW = 12;

    // Bus strobes are combined before the synchroniser so rdAct/wrAct are
    // each a single clean synchronised bit.
    logic [SW-1:0]                  raw;
    logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
    logic                           rdAct, wrAct;
    logic [1:0]                     sReg;
    logic [7:0]                     sData;

    assign raw = {~bus.busCs_n & ~bus.busRd_n, ~bus.busCs_n & ~bus.busWr_n,
                  bus.busReg, bus.busDataIn};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign rdAct = sync_q[SYNC_STAGES-1][11];
    assign wrAct = sync_q[SYNC_STAGES-1][10];
    assign sReg  = sync_q[SYNC_STAGES-1][9:8];
    assign sData = sync_q[SYNC_STAGES-1][7:0];

    logic       rdPrev_q, wrPrev_q, latWr_q;
    logic [1:0] latReg_q;
    logic [7:0] latData_q;
    logic       trail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPrev_q  <= 1'b0;
            wrPrev_q  <= 1'b0;
            latWr_q   <= 1'b0;
            latReg_q  <= '0;
            latData_q <= '0;
        end else begin
            rdPrev_q <= rdAct;
            wrPrev_q <= wrAct;
            if (rdAct | wrAct) begin
                latReg_q  <= sReg;
                latData_q <= sData;
                latWr_q   <= wrAct;  // write wins if both strobes are active
            end
        end
    end

    assign trail = (rdPrev_q & ~rdAct) | (wrPrev_q & ~wrAct);

    state_t            state_q, state_d;
    logic              cmdFull_q, cmdFull_d, cmdWr_q, cmdWr_d;
    logic [1:0]        cmdReg_q, cmdReg_d, step_q, step_d;
    logic [7:0]        cmdData_q, cmdData_d, prefetch_q, prefetch_d;
    logic [7:0]        hostWrData_q, hostWrData_d, busDataOut_q, busDataOut_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, hostAddr_q, hostAddr_d, inc;
    logic              overrun_q, overrun_d, busy;
    logic [7:0]        ptrHi;

    always_comb begin
        inc = '0;
        case (step_q)
            2'd0: inc = ADDR_W'(1);
            2'd1: inc = ADDR_W'(2);
            2'd2: inc = ADDR_W'(160);
            default: inc = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cmdFull_d    = cmdFull_q;
        cmdWr_d      = cmdWr_q;
        cmdReg_d     = cmdReg_q;
        cmdData_d    = cmdData_q;
        step_d       = step_q;
        ptr_d        = ptr_q;
        prefetch_d   = prefetch_q;
        overrun_d    = overrun_q;
        hostAddr_d   = hostAddr_q;
        hostWrData_d = hostWrData_q;

        case (state_q)
            IDLE: if (cmdFull_q) begin
                cmdFull_d = 1'b0;
                case ({cmdWr_q, cmdReg_q})
                    3'b1_00: begin ptr_d[7:0] = cmdData_q; state_d = FETCH; end
                    3'b1_01: begin
                        ptr_d[ADDR_W-1:8] = cmdData_q[ADDR_W-9:0];
                        state_d = FETCH;
                    end
                    3'b1_10: state_d = WRITE;
                    3'b1_11: begin
                        step_d = cmdData_q[1:0];
                        if (cmdData_q[7]) overrun_d = 1'b0;
                    end
                    3'b0_10: begin ptr_d = ptr_q + inc; state_d = FETCH; end
                    default: ;
                endcase
            end
            WRITE: begin
                ptr_d   = ptr_q + inc;
                state_d = FETCH;
            end
            FETCH:   state_d = CAPTURE;
            default: begin
                prefetch_d = bus.hostRdData;
                state_d    = IDLE;
            end
        endcase

        // Address/data are staged one cycle early so they are valid with the strobe.
        if (state_d == WRITE || state_d == FETCH) hostAddr_d = ptr_d;
        if (state_d == WRITE) hostWrData_d = cmdData_q;

        if (trail) begin
            if (cmdFull_q || state_q != IDLE) begin
                overrun_d = 1'b1;
            end else begin
                cmdFull_d = 1'b1;
                cmdWr_d   = latWr_q;
                cmdReg_d  = latReg_q;
                cmdData_d = latData_q;
            end
        end
    end

    assign busy = (state_q != IDLE) | cmdFull_q;

    always_comb begin
        ptrHi = '0;
        ptrHi[ADDR_W-9:0] = ptr_q[ADDR_W-1:8];
        busDataOut_d = '0;
        case (sReg)
            2'd0:    busDataOut_d = ptr_q[7:0];
            2'd1:    busDataOut_d = ptrHi;
            2'd2:    busDataOut_d = prefetch_q;
            default: busDataOut_d = {busy, overrun_q, 4'b0, step_q};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cmdFull_q    <= 1'b0;
            cmdWr_q      <= 1'b0;
            cmdReg_q     <= '0;
            cmdData_q    <= '0;
            step_q       <= '0;
            ptr_q        <= '0;
            prefetch_q   <= '0;
            overrun_q    <= 1'b0;
            hostAddr_q   <= '0;
            hostWrData_q <= '0;
            busDataOut_q <= '0;
        end else begin
            state_q      <= state_d;
            cmdFull_q    <= cmdFull_d;
            cmdWr_q      <= cmdWr_d;
            cmdReg_q     <= cmdReg_d;
            cmdData_q    <= cmdData_d;
            step_q       <= step_d;
            ptr_q        <= ptr_d;
            prefetch_q   <= prefetch_d;
            overrun_q    <= overrun_d;
            hostAddr_q   <= hostAddr_d;
            hostWrData_q <= hostWrData_d;
            busDataOut_q <= busDataOut_d;
        end
    end

    // Strobes decode straight from state so reset kills them asynchronously.
    assign bus.hostSelect = (state_q == WRITE) | (state_q == FETCH);
    assign bus.hostRd     = (state_q != WRITE);
    assign bus.hostAddr   = hostAddr_q;
    assign bus.hostWrData = hostWrData_q;
    assign bus.busDataOut = busDataOut_q;
    assign bus.busDataOe  = rdAct;
endmodule

// File: tb/tb_host_bus_iface.sv
// Directed bench for host_bus_iface with a small VRAM model on the host port.
module tb_host_bus_iface;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    host_bus_iface_if #(.ADDR_W(13)) ifc ();
    host_bus_iface #(.SYNC_STAGES(2), .ADDR_W(13)) dut (.clk(clk), .rst(rst), .bus(ifc));

    logic [7:0]  mem [0:8191];
    logic [7:0]  rdq = 8'h00;
    logic        pre_en = 1'b0;
    logic [12:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    int          sel_cnt = 0;
    int          wr_cnt  = 0;
    int          checks  = 0;
    int          errors  = 0;

    assign ifc.hostRdData = rdq;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (ifc.hostSelect && !ifc.hostRd) mem[ifc.hostAddr] <= ifc.hostWrData;
        if (ifc.hostSelect && ifc.hostRd) rdq <= mem[ifc.hostAddr];
        if (ifc.hostSelect) sel_cnt <= sel_cnt + 1;
        if (ifc.hostSelect && !ifc.hostRd) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] r, input logic [7:0] d);
        @(negedge clk);
        ifc.busReg = r; ifc.busDataIn = d; ifc.busCs_n = 1'b0; ifc.busWr_n = 1'b0;
        repeat (4) @(negedge clk);
        ifc.busCs_n = 1'b1; ifc.busWr_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [7:0] d);
        @(negedge clk);
        ifc.busReg = r; ifc.busCs_n = 1'b0; ifc.busRd_n = 1'b0;
        repeat (5) @(negedge clk);
        d = ifc.busDataOut;
        check("busDataOe_during_read", 16'(ifc.busDataOe), 16'h1);
        ifc.busCs_n = 1'b1; ifc.busRd_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic set_ptr(input logic [7:0] hi, input logic [7:0] lo);
        bus_write(2'd1, hi);
        bus_write(2'd0, lo);
    endtask

    initial begin
        logic [7:0] rd;
        int         w0;
        logic       found;
        ifc.busCs_n = 1'b1; ifc.busRd_n = 1'b1; ifc.busWr_n = 1'b1;
        ifc.busReg = 2'd0; ifc.busDataIn = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: reset state
        check("rst_hostSelect", 16'(ifc.hostSelect), 16'h0);
        check("rst_hostRd", 16'(ifc.hostRd), 16'h1);
        check("rst_hostAddr", 16'(ifc.hostAddr), 16'h0);
        check("rst_busDataOut", 16'(ifc.busDataOut), 16'h0);
        check("rst_busDataOe", 16'(ifc.busDataOe), 16'h0);
        bus_read(2'd3, rd); check("t1_status", 16'(rd), 16'h00);
        check("t1_no_select", 16'(sel_cnt), 16'h0);
        bus_read(2'd2, rd); check("t1_prefetch", 16'(rd), 16'h00);

        // 2: writes with step +1
        w0 = wr_cnt;
        set_ptr(8'h01, 8'h40);
        bus_write(2'd2, 8'h41);
        bus_write(2'd2, 8'h1F);
        check("t2_mem140", 16'(mem[13'h0140]), 16'h41);
        check("t2_mem141", 16'(mem[13'h0141]), 16'h1F);
        check("t2_wr_cnt", 16'(wr_cnt - w0), 16'h2);
        bus_read(2'd0, rd); check("t2_ptr_lo", 16'(rd), 16'h42);
        bus_read(2'd1, rd); check("t2_ptr_hi", 16'(rd), 16'h01);

        // 3: read prefetch with step +2
        preload(13'h0200, 8'h55);
        preload(13'h0202, 8'h66);
        bus_write(2'd3, 8'h01);
        set_ptr(8'h02, 8'h00);
        bus_read(2'd2, rd); check("t3_read0", 16'(rd), 16'h55);
        bus_read(2'd2, rd); check("t3_read1", 16'(rd), 16'h66);
        bus_read(2'd3, rd); check("t3_status", 16'(rd), 16'h01);

        // 4: pointer wrap at top of VRAM
        preload(13'h0000, 8'h3C);
        bus_write(2'd3, 8'h00);
        set_ptr(8'h1F, 8'hFF);
        bus_write(2'd2, 8'hAA);
        check("t4_mem1fff", 16'(mem[13'h1FFF]), 16'hAA);
        bus_read(2'd0, rd); check("t4_ptr_lo", 16'(rd), 16'h00);
        bus_read(2'd1, rd); check("t4_ptr_hi", 16'(rd), 16'h00);
        bus_read(2'd2, rd); check("t4_prefetch", 16'(rd), 16'h3C);

        // 4b: +160 wrap, 8100+160 -> 68
        preload(13'h0044, 8'h77);
        bus_write(2'd3, 8'h02);
        set_ptr(8'h1F, 8'hA4);
        bus_write(2'd2, 8'h12);
        check("t4b_mem1fa4", 16'(mem[13'h1FA4]), 16'h12);
        bus_read(2'd0, rd); check("t4b_ptr_lo", 16'(rd), 16'h44);
        bus_read(2'd1, rd); check("t4b_ptr_hi", 16'(rd), 16'h00);
        bus_read(2'd2, rd); check("t4b_prefetch", 16'(rd), 16'h77);

        // 5: trailing edges 3 cycles apart -> overrun
        preload(13'h0301, 8'h00);
        bus_write(2'd3, 8'h00);
        set_ptr(8'h03, 8'h00);
        w0 = wr_cnt;
        @(negedge clk);
        ifc.busReg = 2'd2; ifc.busDataIn = 8'h5A; ifc.busCs_n = 1'b0; ifc.busWr_n = 1'b0;
        repeat (3) @(negedge clk);
        ifc.busCs_n = 1'b1; ifc.busWr_n = 1'b1;
        @(negedge clk);
        ifc.busDataIn = 8'hA5; ifc.busCs_n = 1'b0; ifc.busWr_n = 1'b0;
        repeat (2) @(negedge clk);
        ifc.busCs_n = 1'b1; ifc.busWr_n = 1'b1;
        repeat (14) @(negedge clk);
        check("t5_mem300", 16'(mem[13'h0300]), 16'h5A);
        check("t5_mem301", 16'(mem[13'h0301]), 16'h00);
        check("t5_wr_cnt", 16'(wr_cnt - w0), 16'h1);
        bus_read(2'd3, rd); check("t5_overrun_set", 16'(rd), 16'h40);
        bus_write(2'd3, 8'h80);
        bus_read(2'd3, rd); check("t5_overrun_clr", 16'(rd), 16'h00);

        // 6: reset on entry to WRITE aborts the access
        preload(13'h0400, 8'h11);
        set_ptr(8'h04, 8'h00);
        w0 = wr_cnt;
        found = 1'b0;
        @(negedge clk);
        ifc.busReg = 2'd2; ifc.busDataIn = 8'hEE; ifc.busCs_n = 1'b0; ifc.busWr_n = 1'b0;
        repeat (3) @(negedge clk);
        ifc.busCs_n = 1'b1; ifc.busWr_n = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk); #1;
            if (ifc.hostSelect && !ifc.hostRd) begin
                rst = 1'b1;
                found = 1'b1;
            end
        end
        check("t6_write_seen", 16'(found), 16'h1);
        #1;
        check("t6_sel_drop", 16'(ifc.hostSelect), 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_hostSelect", 16'(ifc.hostSelect), 16'h0);
        check("t6_hostRd", 16'(ifc.hostRd), 16'h1);
        check("t6_hostAddr", 16'(ifc.hostAddr), 16'h0);
        check("t6_hostWrData", 16'(ifc.hostWrData), 16'h0);
        check("t6_busDataOut", 16'(ifc.busDataOut), 16'h0);
        check("t6_busDataOe", 16'(ifc.busDataOe), 16'h0);
        check("t6_mem400", 16'(mem[13'h0400]), 16'h11);
        check("t6_wr_cnt", 16'(wr_cnt - w0), 16'h0);
        bus_read(2'd3, rd); check("t6_status", 16'(rd), 16'h00);
        bus_read(2'd0, rd); check("t6_ptr_lo", 16'(rd), 16'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/host_bus_iface.md
# host_bus_iface

Host-side port of the text-mode VGA core: converts an asynchronous 8-bit microcontroller bus into single-cycle synchronous accesses on the host port of the VRAM (hostAddr/hostWrData/hostSelect/hostRd/hostRdData). It sits directly upstream of the VRAM and replaces the constant tie-offs on that port. The host sees four byte registers:

- an auto-incrementing address pointer;
- a DATA window with read prefetch;
- a control/status register.

## Interface
- SYNC_STAGES, 2: flip-flop stages on every async bus input (minimum 2).
- ADDR_W, 13: VRAM address width; the pointer wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  VGA dot clock (global buffer), all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- busCs_n  in  1  host chip select, async, active low
- busRd_n  in  1  host read strobe, async, active low
- busWr_n  in  1  host write strobe, async, active low
- busReg  in  2  register select: 0 ADDR_LO, 1 ADDR_HI, 2 DATA, 3 CTRL/STATUS
- busDataIn  in  8  host write data
- busDataOut  out  8  registered read data for the host
- busDataOe  out  1  drive enable for the external data bus buffer
- hostAddr  out  ADDR_W  VRAM host address
- hostWrData  out  8  VRAM write data
- hostSelect  out  1  one-cycle VRAM access strobe
- hostRd  out  1  1 = read, 0 = write (qualifies hostSelect)
- hostRdData  in  8  VRAM read data, valid the cycle after a read strobe

## Operation
Bus front end:
- busCs_n, busRd_n, busWr_n, busReg and busDataIn pass through SYNC_STAGES flops.
- rdAct = synced(~cs_n & ~rd_n); wrAct = synced(~cs_n & ~wr_n).
- While rdAct or wrAct is high, busReg and busDataIn are latched every cycle.
- A host access takes effect on its trailing edge: the 1→0 transition of wrAct or rdAct.
- At that edge a one-deep command latch {isWrite, reg, data} is loaded.
- If the latch is still full, or the FSM is not IDLE, the new command is dropped and the sticky overrun flag is set.

Read path:
- busDataOut is registered every cycle from a mux on the synced busReg:
  - reg 0: ptr[7:0]
  - reg 1: {3'b0, ptr[12:8]}
  - reg 2: prefetch
  - reg 3: {busy, overrun, 4'b0, step[1:0]}
- busDataOe = rdAct.

Increment step codes: 0 → +1, 1 → +2, 2 → +160 (one text row of char/attr pairs), 3 → +0. All pointer arithmetic is ADDR_W bits and wraps (8191+1 → 0; 8100+160 → 68).

FSM states: IDLE, WRITE, FETCH, CAPTURE. In IDLE, a full command latch is consumed (latch cleared) as follows:
- ADDR_LO write: ptr[7:0] ← data → FETCH.
- ADDR_HI write: ptr[12:8] ← data[4:0] → FETCH.
- DATA write: → WRITE.
- DATA read: ptr ← ptr + step → FETCH.
- CTRL write: step ← data[1:0]; if data[7], overrun ← 0; stay IDLE.
- Reads of regs 0, 1, 3 and writes with no effect: stay IDLE.

Other states:
- WRITE: hostSelect = 1, hostRd = 0, hostAddr = ptr, hostWrData = data. Then ptr ← ptr + step → FETCH.
- FETCH: hostSelect = 1, hostRd = 1, hostAddr = ptr → CAPTURE.
- CAPTURE: prefetch ← hostRdData → IDLE.

Outputs and flags:
- Outside WRITE/FETCH: hostSelect = 0 and hostRd = 1. hostAddr and hostWrData hold their last values.
- busy = (state ≠ IDLE) | latch full.

Reset values:
- ptr 0, step 0, prefetch 0x00, overrun 0, latch empty, state IDLE.
- hostSelect 0, hostRd 1, hostAddr 0, hostWrData 0, busDataOut 0, busDataOe 0.
- No fetch is issued on reset exit.
- Asserting rst mid-command aborts it immediately. No partial VRAM write can occur, because hostSelect is cleared asynchronously.

## Timing
- Bus input to synced signal: SYNC_STAGES cycles.
- Trailing edge detected in cycle E: the latch is full in E+1 and the FSM acts in E+1.
- DATA write:
  - WRITE strobe in E+2.
  - FETCH strobe in E+3.
  - prefetch updated at end of E+4.
  - IDLE in E+5.
- ADDR write or DATA read: FETCH in E+2, prefetch valid E+4.
- hostSelect is always exactly 1 cycle wide. A WRITE is never immediately followed by another WRITE.
- Host contract: consecutive access trailing edges ≥ 6 + SYNC_STAGES cycles apart. Closer edges set overrun and the second access is dropped.
- Simultaneous rdAct and wrAct (illegal host behaviour) is treated as a write.

## Test plan
1. Reset, then read reg 3 → 0x00. Read reg 2 → 0x00. No hostSelect pulse seen.
2. Write ADDR_HI=0x01, ADDR_LO=0x40, then DATA=0x41 and DATA=0x1F (step 0).
   - VRAM writes at 0x0140=0x41 and 0x0141=0x1F, each with a single-cycle hostSelect, hostRd=0.
   - ptr reads back 0x0142.
3. Preload VRAM[0x0200]=0x55 and [0x0202]=0x66. Write CTRL=0x01, set ptr=0x0200, read DATA twice → 0x55 then 0x66.
4. CTRL=0x00, ptr=0x1FFF, write DATA=0xAA → VRAM[0x1FFF]=0xAA. ptr wraps to 0x0000 and prefetch = VRAM[0].
5. Two DATA writes with trailing edges 3 cycles apart:
   - only the first reaches VRAM;
   - reg 3 bit6 = 1;
   - CTRL write 0x80 clears it.
6. Assert rst on the cycle the FSM enters WRITE → hostSelect drops immediately. After release all outputs are at reset values and VRAM is unchanged.
